// File: rtl/mem_ctrl_if.sv
// mem_ctrl_if: core-side request/response and byte-wide RAM/IO port of mem_ctrl
interface mem_ctrl_if;
  logic [7:0]  mem_din;
  logic [7:0]  mem_dout;
  logic [31:0] mem_a;
  logic        mem_wr;
  logic        io_buffer_full;
  logic        if_sig;
  logic [31:0] if_addr;
  logic        if_done;
  logic [31:0] if_data;
  logic        ls_sig;
  logic        load_or_store;
  logic [2:0]  len;
  logic [31:0] ls_addr;
  logic [31:0] store_val;
  logic        ls_done;
  logic [31:0] ls_data;
  logic        clear;
  modport slave (
    input  mem_din, io_buffer_full, if_sig, if_addr, ls_sig, load_or_store, len, ls_addr, store_val, clear,
    output mem_dout, mem_a, mem_wr, if_done, if_data, ls_done, ls_data
  );
  modport master (
    output mem_din, io_buffer_full, if_sig, if_addr, ls_sig, load_or_store, len, ls_addr, store_val, clear,
    input  mem_dout, mem_a, mem_wr, if_done, if_data, ls_done, ls_data
  );
endinterface

// File: rtl/mem_ctrl.sv
// mem_ctrl: byte-serial RAM/IO controller arbitrating instruction fetch and load/store requests
module mem_ctrl (
  input  logic      clk,
  input  logic      rst,
  input  logic      rdy,
  mem_ctrl_if.slave b
);
  typedef enum logic [1:0] {IDLE, READ, WRITE, DONE} state_t;
  state_t st, st_n;
  logic id, last_grant, is_st, win, grant, stall;
  logic [2:0] n, cnt;
  logic [31:0] addr, sval, asm_q, word, if_data_q, ls_data_q;
  // requester ids: 0 = fetch, 1 = load/store
  assign win = (b.if_sig && b.ls_sig) ? ~last_grant : b.ls_sig;
  assign grant = st == IDLE && !b.clear && (b.if_sig || b.ls_sig);
  assign b.mem_a = (st == READ || st == WRITE) ? addr + {29'd0, cnt} : 32'd0;
  assign b.mem_dout = st == WRITE ? sval[{cnt[1:0], 3'b000} +: 8] : 8'd0;
  assign stall = b.mem_a[17:16] == 2'b11 && b.io_buffer_full;
  assign b.mem_wr = st == WRITE && rdy && !stall;
  assign b.if_done = st == DONE && !id && rdy && !b.clear;
  assign b.ls_done = st == DONE && id && rdy && !(b.clear && !is_st);
  assign b.if_data = if_data_q;
  assign b.ls_data = ls_data_q;
  // RAM byte arriving now belongs to the address issued last cycle
  always_comb begin
    word = asm_q;
    word[{cnt[1:0] - 2'd1, 3'b000} +: 8] = b.mem_din;
  end
  always_comb begin
    st_n = st;
    case (st)
      IDLE:  st_n = grant ? (win && b.load_or_store ? WRITE : READ) : IDLE;
      READ:  st_n = b.clear ? IDLE : cnt == n ? DONE : READ;
      WRITE: st_n = !stall && cnt == n - 3'd1 ? DONE : WRITE;
      DONE:  st_n = IDLE;
    endcase
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      st <= IDLE;
      id <= 1'b0;
      last_grant <= 1'b0;
      is_st <= 1'b0;
      n <= 3'd0;
      cnt <= 3'd0;
      addr <= '0;
      sval <= '0;
      asm_q <= '0;
      if_data_q <= '0;
      ls_data_q <= '0;
    end else if (rdy) begin
      st <= st_n;
      if (grant) begin
        id <= win;
        last_grant <= win;
        is_st <= win && b.load_or_store;
        addr <= win ? b.ls_addr : b.if_addr;
        sval <= b.store_val;
        n <= !win || (b.len != 3'd1 && b.len != 3'd2) ? 3'd4 : b.len;
        cnt <= 3'd0;
        asm_q <= '0;
      end else if (st == READ) begin
        cnt <= cnt + 3'd1;
        if (cnt != 3'd0) asm_q <= word;
        if (cnt == n && !id) if_data_q <= word;
        if (cnt == n && id) ls_data_q <= word;
      end else if (st == WRITE && !stall) cnt <= cnt + 3'd1;
    end
  end
endmodule

// File: doc/mem_ctrl.md
# mem_ctrl

Byte-serial memory controller between the core and the 8-bit unified RAM/IO port. Serves two requesters: instruction fetch (4-byte reads) and the load/store buffer (1/2/4-byte loads and stores), with round-robin arbitration. Assembles little-endian words from RAM bytes, splits stores into byte writes, honours IO back-pressure, and aborts speculative reads on pipeline clear.

## Interface
- No parameters.
- clk  in  1  system clock
- rst  in  1  reset, synchronous, active-high
- rdy  in  1  global enable; low freezes all state, forces mem_wr=0
- mem_din  in  8  RAM read byte (valid one cycle after its address)
- mem_dout  out  8  RAM write byte
- mem_a  out  32  RAM byte address
- mem_wr  out  1  1 = write mem_dout to mem_a this cycle
- io_buffer_full  in  1  IO sink full; stalls writes to IO space (mem_a[17:16]==2'b11)
- if_sig  in  1  fetch request, held until if_done
- if_addr  in  32  fetch address
- if_done  out  1  one-cycle pulse, if_data valid
- if_data  out  32  fetched word
- ls_sig  in  1  load/store request, held until ls_done
- load_or_store  in  1  0 load, 1 store
- len  in  3  byte count: 1, 2 or 4
- ls_addr  in  32  access address
- store_val  in  32  store data, low len bytes used
- ls_done  out  1  one-cycle pulse; load data valid / store complete
- ls_data  out  32  load data, zero-extended (sign extension is the buffer's job)
- clear  in  1  pipeline flush

## Operation
- States: IDLE, READ, WRITE, DONE. Registers: requester id, addr, n (byte count), cnt (0..4), 32-bit assembly buffer, last_grant.
- IDLE: if clear=0 and any request pending, grant: only one pending -> that one; both -> the one not equal to last_grant. Latch addr/len/store_val (fetch: n=4). Load/fetch -> READ; store -> WRITE. cnt<=0, last_grant<=winner.
- READ: mem_wr=0; for cnt<n mem_a=addr+cnt; for cnt>=1 capture mem_din into byte cnt-1 of buffer. At cnt==n capture last byte, -> DONE.
- WRITE: mem_a=addr+cnt, mem_dout=store_val byte cnt, mem_wr=1, cnt++; if mem_a IO-space and io_buffer_full=1: mem_wr=0, cnt holds. After byte n-1 written -> DONE.
- DONE: pulse the served requester's done with buffer (unused high bytes 0); no new grant this cycle; -> IDLE.
- Address arithmetic 32-bit, wraps modulo 2^32. mem_a/mem_dout/mem_wr combinational from state regs; done/data registered.
- len other than 1/2: treated as 4.
- clear: in READ or in DONE of a read -> abort, no done pulse, -> IDLE. WRITE is committed: completes and pulses ls_done regardless of clear. IDLE with clear=1: no grant.
- rst: state IDLE, cnt 0, last_grant=fetch, all outputs 0 (if_done, ls_done, if_data, ls_data, mem_a, mem_dout, mem_wr). Reset mid-transfer abandons it with no done pulse.

## Timing
- Request sampled in IDLE at cycle T -> transfer starts T+1.
- Read of n bytes: addresses in T+1..T+n, last capture end of T+1+n, done pulse in T+2+n (4-byte: T+6).
- Write of n bytes without stall: mem_wr=1 in T+1..T+n, ls_done in T+n+1; each IO stall cycle adds one.
- Back-to-back: next grant no earlier than done cycle +1; requester drops sig in cycle after done.
- rdy=0: no state change, no done pulse, mem_wr=0; resumes exactly where it stopped.

## Test plan
- Fetch 0x00000010, RAM bytes 13,05,00,00 -> if_done in T+6, if_data=0x00000513, mem_wr never 1.
- Load len=2 at 0x100 bytes 0xFE,0xFF -> ls_done at T+4, ls_data=0x0000FFFE; len=1 -> 0x000000FE at T+3.
- Store len=4 0xDEADBEEF to 0x200 -> writes EF,BE,AD,DE to 0x200..0x203 in T+1..T+4, ls_done T+5.
- Store len=1 0x41 to 0x30000 with io_buffer_full high 3 cycles -> mem_wr held 0 for 3 cycles, then one write, ls_done delayed by 3.
- if_sig and ls_sig held together continuously from reset -> grants alternate LSB, IF, LSB, IF.
- clear during READ cnt=2 of a fetch -> no if_done, IDLE next cycle; clear during store -> store finishes, ls_done pulses; rdy low 2 cycles mid-load -> done delayed exactly 2.
